// File: rtl/alu_pkg.sv
// Shared types and widths for the alu_bus initiator and its users.
package alu_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_DIV = 3'd4,
        OP_AND = 3'd5,
        OP_OR  = 3'd6,
        OP_NOT = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } drv_state_e;

endpackage

// File: rtl/alu_driver_if.sv
// alu_bus: operation/operand lines into the combinational alu and its result.
interface alu_bus;
    import alu_pkg::*;

    alu_op_e           op;
    logic [DATA_W-1:0] operand_1;
    logic [DATA_W-1:0] operand_2;
    logic [DATA_W-1:0] result;

    modport master (output op, output operand_1, output operand_2, input result);
    modport slave  (input op, input operand_1, input operand_2, output result);

endinterface

// File: rtl/alu_driver_stats.sv
// Response handshake counters; compiled only when ALU_DRIVER_STATS_EN is defined.
`ifdef ALU_DRIVER_STATS_EN
module alu_driver_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        fire,
    input  logic        err,
    output logic [31:0] stat_ops,
    output logic [31:0] stat_errs
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (fire) begin
            stat_ops <= stat_ops + 32'd1;
            if (err) stat_errs <= stat_errs + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/alu_driver.sv
// Initiator on alu_bus: accepts commands, drives the alu for SETTLE_CYCLES, returns tagged results.
// Optional handshake statistics under macro ALU_DRIVER_STATS_EN.
module alu_driver
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  alu_op_e           cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
`ifdef ALU_DRIVER_STATS_EN
    output logic [31:0]       stat_ops,
    output logic [31:0]       stat_errs,
`endif
    alu_bus.master            alu
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    drv_state_e        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    alu_op_e           op_r, op_nx;
    logic [DATA_W-1:0] opnd_1, opnd_1_nx, opnd_2, opnd_2_nx;
    logic              valid_nx, err_nx;
    logic [DATA_W-1:0] result_nx;
    logic [TAG_W-1:0]  tag_nx;
    logic              accept;

    assign alu.op        = op_r;
    assign alu.operand_1 = opnd_1;
    assign alu.operand_2 = opnd_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_r       <= OP_NOP;
            opnd_1     <= '0;
            opnd_2     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            op_r       <= op_nx;
            opnd_1     <= opnd_1_nx;
            opnd_2     <= opnd_2_nx;
            rsp_valid  <= valid_nx;
            rsp_result <= result_nx;
            rsp_tag    <= tag_nx;
            rsp_err    <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        op_nx     = op_r;
        opnd_1_nx = opnd_1;
        opnd_2_nx = opnd_2;
        valid_nx  = rsp_valid;
        result_nx = rsp_result;
        tag_nx    = rsp_tag;
        err_nx    = rsp_err;

        cmd_ready = !rst && ((state == IDLE) || (state == RESP && rsp_ready));
        accept    = cmd_valid && cmd_ready;

        case (state)
            DRIVE: begin
                if (cnt == '0) begin
                    result_nx = alu.result;
                    err_nx    = 1'b0;
                    valid_nx  = 1'b1;
                    op_nx     = OP_NOP;
                    state_nx  = RESP;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: ;
        endcase

        // A new command overrides the RESP release so back-to-back transfers leave no idle cycle.
        if (accept) begin
            tag_nx = cmd_tag;
            if (cmd_op == OP_DIV && cmd_b == '0) begin
                result_nx = '1;
                err_nx    = 1'b1;
                valid_nx  = 1'b1;
                state_nx  = RESP;
            end else if (cmd_op == OP_NOP) begin
                result_nx = '0;
                err_nx    = 1'b0;
                valid_nx  = 1'b1;
                state_nx  = RESP;
            end else begin
                op_nx     = cmd_op;
                opnd_1_nx = cmd_a;
                opnd_2_nx = cmd_b;
                cnt_nx    = CNT_W'(SETTLE_CYCLES - 1);
                valid_nx  = 1'b0;
                state_nx  = DRIVE;
            end
        end
    end

`ifdef ALU_DRIVER_STATS_EN
    alu_driver_stats u_stats (
        .clk       (clk),
        .rst       (rst),
        .fire      (rsp_valid && rsp_ready),
        .err       (rsp_err),
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs)
    );
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: instance 0 with SETTLE_CYCLES=1, instance 1 with SETTLE_CYCLES=3.
module tb_alu_driver;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    alu_op_e     cmd_op [2];
    logic [15:0] cmd_a [2];
    logic [15:0] cmd_b [2];
    logic [3:0]  cmd_tag [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_result [2];
    logic [3:0]  rsp_tag [2];
    logic        rsp_err [2];
    logic [2:0]  alu_op_w [2];
    logic [15:0] opnd1_w [2];
    logic [15:0] opnd2_w [2];
    int          settle [2];
    int          checks = 0;
    int          errors = 0;
    int          hs_ops = 0;
    int          hs_errs = 0;

    alu_bus bus0 ();
    alu_bus bus1 ();

    // Stand-in for the combinational alu sitting on the bus.
    function automatic logic [15:0] alu_env(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        case (op)
            3'd1:    return x + y;
            3'd2:    return x - y;
            3'd3:    return x * y;
            3'd4:    return (y == 16'd0) ? 16'd0 : x / y;
            3'd5:    return x & y;
            3'd6:    return x | y;
            3'd7:    return ~x;
            default: return 16'd0;
        endcase
    endfunction

    assign bus0.result = alu_env(bus0.op, bus0.operand_1, bus0.operand_2);
    assign bus1.result = alu_env(bus1.op, bus1.operand_1, bus1.operand_2);
    assign alu_op_w[0] = bus0.op;
    assign alu_op_w[1] = bus1.op;
    assign opnd1_w[0]  = bus0.operand_1;
    assign opnd1_w[1]  = bus1.operand_1;
    assign opnd2_w[0]  = bus0.operand_2;
    assign opnd2_w[1]  = bus1.operand_2;

`ifdef ALU_DRIVER_STATS_EN
    logic [31:0] stat_ops0, stat_errs0, stat_ops1, stat_errs1;
`endif

    alu_driver #(.TAG_W(4), .SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_tag(cmd_tag[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
        .rsp_tag(rsp_tag[0]), .rsp_err(rsp_err[0]),
`ifdef ALU_DRIVER_STATS_EN
        .stat_ops(stat_ops0), .stat_errs(stat_errs0),
`endif
        .alu(bus0)
    );

    alu_driver #(.TAG_W(4), .SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_tag(cmd_tag[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
        .rsp_tag(rsp_tag[1]), .rsp_err(rsp_err[1]),
`ifdef ALU_DRIVER_STATS_EN
        .stat_ops(stat_ops1), .stat_errs(stat_errs1),
`endif
        .alu(bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected response from the command alone, using modular integer arithmetic.
    task automatic ref_rsp(input alu_op_e op, input int unsigned a, input int unsigned b,
                           output logic [15:0] res, output logic err);
        int unsigned r;
        err = 1'b0;
        case (op)
            OP_ADD:  r = (a + b) % 65536;
            OP_SUB:  r = (a + 65536 - b) % 65536;
            OP_MUL:  r = (a * b) % 65536;
            OP_DIV:  if (b == 0) begin r = 65535; err = 1'b1; end else r = a / b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOT:  r = 65535 - a;
            default: r = 0;
        endcase
        res = r[15:0];
    endtask

    task automatic finish_rsp(input int d, input logic [15:0] er, input logic [3:0] et,
                              input logic ee, input int hold);
        for (int i = 0; i < hold; i++) begin
            check("hold_ready", cmd_ready[d], 1'b0);
            check("hold_valid", rsp_valid[d], 1'b1);
            check("hold_result", rsp_result[d], er);
            check("hold_tag", rsp_tag[d], et);
            @(negedge clk);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("rsp_release", rsp_valid[d], 1'b0);
        if (d == 0) begin
            hs_ops++;
            if (ee) hs_errs++;
        end
    endtask

    // Latency is counted in negedge samples after the accept edge.
    task automatic run_txn(input int d, input alu_op_e op, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] tag, input int hold);
        logic [15:0] er;
        logic        ee;
        logic        bypass;
        int          lat;
        ref_rsp(op, a, b, er, ee);
        bypass = (op == OP_NOP) || (op == OP_DIV && b == 16'd0);
        cmd_valid[d] = 1'b1; cmd_op[d] = op; cmd_a[d] = a; cmd_b[d] = b; cmd_tag[d] = tag;
        #1;
        lat = 0;
        while (!cmd_ready[d] && lat < 20) begin @(negedge clk); lat++; end
        check("accept", cmd_ready[d], 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        cmd_a[d] = 16'($urandom);
        cmd_b[d] = 16'($urandom);
        check("drive_op", alu_op_w[d], bypass ? OP_NOP : op);
        if (!bypass) begin
            check("drive_a", opnd1_w[d], a);
            check("drive_b", opnd2_w[d], b);
        end
        lat = 1;
        while (!rsp_valid[d] && lat < 20) begin @(negedge clk); lat++; end
        check("latency", lat, bypass ? 1 : settle[d] + 1);
        check("result", rsp_result[d], er);
        check("tag", rsp_tag[d], tag);
        check("err", rsp_err[d], ee);
        check("resp_op", alu_op_w[d], OP_NOP);
        finish_rsp(d, er, tag, ee, hold);
    endtask

    alu_op_e     dir_op [9] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_DIV, OP_NOP};
    logic [15:0] dir_a  [9] = '{16'd1, 16'd1, 16'd2, 16'd4, 16'd5, 16'd5, 16'hAAAA, 16'd4, 16'd9};
    logic [15:0] dir_b  [9] = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd4, 16'd4, 16'd0, 16'd0, 16'd9};

    task automatic rand_txn(input int d);
        alu_op_e     op;
        logic [15:0] b;
        op = alu_op_e'($urandom_range(0, 7));
        b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        run_txn(d, op, 16'($urandom), b, 4'($urandom), int'($urandom_range(0, 3)));
    endtask

    initial begin
        settle[0] = 1;
        settle[1] = 3;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cmd_valid[d] = 1'b0; cmd_op[d] = OP_NOP;
            cmd_a[d] = '0; cmd_b[d] = '0; cmd_tag[d] = '0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", cmd_ready[d], 1'b0);
            check("rst_valid", rsp_valid[d], 1'b0);
            check("rst_result", rsp_result[d], 16'd0);
            check("rst_tag", rsp_tag[d], 4'd0);
            check("rst_err", rsp_err[d], 1'b0);
            check("rst_op", alu_op_w[d], OP_NOP);
            check("rst_opnd", {opnd1_w[d], opnd2_w[d]}, 32'd0);
            rst[d] = 1'b0;
        end
`ifdef ALU_DRIVER_STATS_EN
        check("rst_stat_ops", stat_ops0, 32'd0);
        check("rst_stat_errs", stat_errs0, 32'd0);
`endif
        #1;
        check("idle_ready", cmd_ready[0], 1'b1);

        for (int i = 0; i < 9; i++) run_txn(0, dir_op[i], dir_a[i], dir_b[i], 4'(i + 3), i % 3);

        // Response stall, then rsp handshake and new accept on the same edge.
        cmd_valid[0] = 1'b1; cmd_op[0] = OP_ADD; cmd_a[0] = 16'd1; cmd_b[0] = 16'd1; cmd_tag[0] = 4'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_op[0] = OP_SUB; cmd_a[0] = 16'd7; cmd_b[0] = 16'd3; cmd_tag[0] = 4'd6;
        check("b2b_drive_ready", cmd_ready[0], 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("b2b_stall_valid", rsp_valid[0], 1'b1);
            check("b2b_stall_result", rsp_result[0], 16'd2);
            check("b2b_stall_tag", rsp_tag[0], 4'd5);
            check("b2b_stall_ready", cmd_ready[0], 1'b0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        #1;
        check("b2b_ready", cmd_ready[0], 1'b1);
        @(posedge clk);
        @(negedge clk);
        hs_ops++;
        rsp_ready[0] = 1'b0;
        cmd_valid[0] = 1'b0;
        check("b2b_no_bubble_valid", rsp_valid[0], 1'b0);
        check("b2b_no_bubble_op", alu_op_w[0], OP_SUB);
        check("b2b_no_bubble_a", opnd1_w[0], 16'd7);
        @(negedge clk);
        check("b2b_valid", rsp_valid[0], 1'b1);
        check("b2b_result", rsp_result[0], 16'd4);
        check("b2b_tag", rsp_tag[0], 4'd6);
        finish_rsp(0, 16'd4, 4'd6, 1'b0, 1);

        for (int i = 0; i < 40; i++) rand_txn(0);

`ifdef ALU_DRIVER_STATS_EN
        check("stat_ops", stat_ops0, 32'(hs_ops));
        check("stat_errs", stat_errs0, 32'(hs_errs));
`endif

        for (int i = 0; i < 9; i++) run_txn(1, dir_op[i], dir_a[i], dir_b[i], 4'(i), 1);
        for (int i = 0; i < 10; i++) rand_txn(1);

        // Reset in the second DRIVE cycle drops the transaction.
        cmd_valid[1] = 1'b1; cmd_op[1] = OP_ADD; cmd_a[1] = 16'd3; cmd_b[1] = 16'd4; cmd_tag[1] = 4'd9;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        check("rd_drive_op", alu_op_w[1], OP_ADD);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        check("rd_valid", rsp_valid[1], 1'b0);
        check("rd_op", alu_op_w[1], OP_NOP);
        check("rd_opnd", {opnd1_w[1], opnd2_w[1]}, 32'd0);
        check("rd_result", rsp_result[1], 16'd0);
        check("rd_tag", rsp_tag[1], 4'd0);
        check("rd_err", rsp_err[1], 1'b0);
        check("rd_ready_in_rst", cmd_ready[1], 1'b0);
        rst[1] = 1'b0;
        #1;
        check("rd_ready_after", cmd_ready[1], 1'b1);
        repeat (4) @(negedge clk);
        check("rd_no_rsp", rsp_valid[1], 1'b0);
`ifdef ALU_DRIVER_STATS_EN
        check("rd_stat_ops", stat_ops1, 32'd0);
        check("rd_stat_errs", stat_errs1, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
